prime_gen: RTL and testbench

Sequential prime generator, the producing counterpart to the combinational prime checker. On a start pulse it walks candidates from 2 up to a latched limit. It tests each candidate by trial division, one divisor per clock. Each prime found is streamed out over a valid/ready handshake, and a one-cycle done pulse marks the end of the run. Used to produce prime sequences for downstream hashing and test stimulus.

---
 rtl/prime_gen.sv | 103 ++++++++++
 tb/tb_prime_gen.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/prime_gen.sv
// Sequential prime generator: walks candidates 2..limit, tests each by trial
// division (one divisor per clock) and streams primes over a valid/ready port.
module prime_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] prime_out,
  output logic             prime_valid,
  input  logic             prime_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count
);

  typedef enum logic [2:0] {IDLE, TEST, EMIT, NEXT, FINISH} state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   lim_q;
  logic [WIDTH-1:0]   cand;
  logic [WIDTH-1:0]   div;
  logic [2*WIDTH-1:0] div_sq;
  logic               is_prime;
  logic               is_comp;
  logic               accept;

  // Square formed at double width so large divisors cannot wrap.
  assign div_sq   = {{WIDTH{1'b0}}, div} * {{WIDTH{1'b0}}, div};
  assign is_prime = div_sq > {{WIDTH{1'b0}}, cand};
  assign is_comp  = (cand % div) == '0;
  assign accept   = prime_valid && prime_ready;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) state_nx = (limit < WIDTH'(2)) ? FINISH : TEST;
      end
      TEST: begin
        if (is_prime)     state_nx = EMIT;
        else if (is_comp) state_nx = NEXT;
      end
      EMIT: begin
        if (accept) state_nx = NEXT;
      end
      NEXT: begin
        state_nx = (cand >= lim_q) ? FINISH : TEST;
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Candidate/limit registers carry data only and need no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      prime_out   <= '0;
      prime_valid <= 1'b0;
      done        <= 1'b0;
      count       <= '0;
    end else begin
      state <= state_nx;
      done  <= (state == FINISH);
      case (state)
        IDLE: begin
          if (start) begin
            lim_q <= limit;
            count <= '0;
            cand  <= WIDTH'(2);
            div   <= WIDTH'(2);
          end
        end
        TEST: begin
          if (is_prime) begin
            prime_out   <= cand;
            prime_valid <= 1'b1;
          end else if (!is_comp) begin
            div <= div + WIDTH'(1);
          end
        end
        EMIT: begin
          if (accept) begin
            prime_valid <= 1'b0;
            count       <= count + WIDTH'(1);
          end
        end
        NEXT: begin
          // Compare before incrementing so cand never wraps at the top of range.
          if (cand < lim_q) begin
            cand <= cand + WIDTH'(1);
            div  <= WIDTH'(2);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prime_gen.sv
// Randomized self-checking bench for prime_gen against a plain trial-division
// primality model.
module tb_prime_gen;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] prime_out;
  logic             prime_valid;
  logic             prime_ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] count;

  int n_chk = 0;
  int n_err = 0;

  prime_gen #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .limit(limit),
    .prime_out(prime_out), .prime_valid(prime_valid), .prime_ready(prime_ready),
    .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_prime_m(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++)
      if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  // One complete run; optional random backpressure, a 6-cycle stall on a given
  // prime, and a disturbing start/limit change mid-run.
  task automatic run(input int lim, input bit rnd, input int stall_val, input bit disturb);
    int exp_q[$];
    int total, cyc, stall_cnt, prev_out, n_acc;
    bit stall_on, pend, seen_done;
    exp_q = {};
    for (int n = 2; n <= lim; n++)
      if (is_prime_m(n)) exp_q.push_back(n);
    total = exp_q.size();
    cyc = 1; stall_cnt = 0; prev_out = 0; n_acc = 0;
    stall_on = 1'b0; pend = 1'b0; seen_done = 1'b0;

    @(negedge clk); limit = WIDTH'(lim); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_run", busy, 1);
    while (cyc < 20000 && !seen_done) begin
      @(negedge clk);
      cyc++;
      if (disturb) begin
        if (cyc == 6) begin start = 1'b1; limit = WIDTH'(3); end
        else start = 1'b0;
      end
      prime_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!stall_on && stall_cnt == 0 && prime_valid && int'(prime_out) == stall_val)
        stall_on = 1'b1;
      if (stall_on) begin
        prime_ready = 1'b0;
        chk("stall_valid", prime_valid, 1);
        chk("stall_out", prime_out, stall_val);
        stall_cnt++;
        if (stall_cnt == 6) stall_on = 1'b0;
      end
      if (pend) begin
        chk("hold_valid", prime_valid, 1);
        chk("hold_out", prime_out, prev_out);
      end
      if (cyc == 2) begin
        if (lim >= 2) chk("first_valid_lat", prime_valid, 1);
        else          chk("done_lat", done, 1);
      end
      chk("valid_done_excl", prime_valid && done, 0);
      if (prime_valid && prime_ready) begin
        n_acc++;
        if (exp_q.size() == 0) chk("extra_prime", prime_out, -1);
        else chk("prime", prime_out, exp_q.pop_front());
      end
      pend = prime_valid && !prime_ready;
      prev_out = prime_out;
      if (done) seen_done = 1'b1;
    end
    prime_ready = 1'b1;
    chk("done_seen", seen_done, 1);
    chk("n_primes", n_acc, total);
    chk("count", count, total);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_idle", busy, 0);
    chk("count_hold", count, total);
  endtask

  task automatic reset_mid();
    bit hit;
    int cyc;
    hit = 1'b0; cyc = 0;
    @(negedge clk); limit = WIDTH'(50); start = 1'b1; prime_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!hit && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (prime_valid && prime_out == WIDTH'(7)) hit = 1'b1;
    end
    chk("reach_7", hit, 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_prime_out", prime_out, 0);
    chk("rst_valid", prime_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    repeat (5) begin
      @(negedge clk);
      chk("no_done_after_rst", done, 0);
      chk("idle_after_rst", busy, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; limit = '0; prime_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_prime_out", prime_out, 0);
    chk("reset_valid", prime_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_count", count, 0);
    rst = 1'b0;

    run(20, 1'b0, -1, 1'b0);
    run(1, 1'b0, -1, 1'b0);
    run(0, 1'b0, -1, 1'b0);
    run(2, 1'b0, -1, 1'b0);
    run(10, 1'b0, 3, 1'b0);
    run(255, 1'b1, -1, 1'b0);
    reset_mid();
    run(5, 1'b0, -1, 1'b0);
    run(20, 1'b0, -1, 1'b1);
    repeat (3) run(int'($urandom_range(0, 80)), 1'b1, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
